// File: rtl/fixed_div_pkg.sv
// Shared definitions for the sign-magnitude fixed-point arithmetic blocks
// (divider and its multiplier companion).
//   Q_DEFAULT / N_DEFAULT : default fraction bits and total word width
//   div_state_t           : divider FSM state encoding
//   sign_bit()            : index of the sign bit for an N-bit word
package fixed_div_pkg;

  localparam int Q_DEFAULT = 16;
  localparam int N_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

  function automatic int sign_bit(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/fixed_div.sv
// Iterative restoring radix-2 divider for sign-magnitude QN fixed point.
// One quotient bit per clock; fixed latency of N+Q cycles from accept to ready_o.
// Ports:
//   clk_i, nrst_i       clock (rising edge), async active-low reset
//   valid_i             operands valid, accepted only in IDLE
//   opA_i, opB_i        dividend, divisor (sign-magnitude QN)
//   busy_o              division in progress, valid_i ignored
//   ready_o             one-cycle pulse when result_o and flags update
//   result_o            quotient (sign-magnitude QN), held until next ready_o
//   div_zero_o          last result came from a zero-magnitude divisor
//   overflow_o          last result saturated
//
// state   | meaning
// IDLE    | waiting for valid_i, operands captured on accept
// CALC    | N-1+Q shift/compare/subtract iterations
// DONE    | register result and flags, pulse ready_o
module fixed_div
  import fixed_div_pkg::*;
#(
  parameter int Q = Q_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  input  logic         valid_i,
  input  logic [N-1:0] opA_i,
  input  logic [N-1:0] opB_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic [N-1:0] result_o,
  output logic         div_zero_o,
  output logic         overflow_o
);

  localparam int DW = N - 1 + Q;
  localparam int CW = $clog2(N + Q);
  localparam int SIGN_BIT = sign_bit(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);
  localparam logic [N-2:0] MAG_MAX = '1;

  div_state_t    state;
  // quo starts as the shifted dividend; its MSB feeds the remainder each
  // iteration while the new quotient bit enters at the LSB, so after DW
  // iterations it holds the full quotient.
  logic [DW-1:0] quo;
  logic [N-1:0]  rem;
  logic [N-2:0]  divisor;
  logic          sign;
  logic [CW-1:0] cnt;

  logic [N-1:0]  rem_sh;
  logic [N-1:0]  rem_nx;
  logic [DW-1:0] quo_nx;
  logic          take;
  logic          div_zero;
  logic          ovf;
  logic [N-2:0]  mag;

  always_comb begin
    rem_sh   = (rem << 1) | {{(N-1){1'b0}}, quo[DW-1]};
    take     = (rem_sh >= {1'b0, divisor});
    rem_nx   = take ? (rem_sh - {1'b0, divisor}) : rem_sh;
    quo_nx   = {quo[DW-2:0], take};
    div_zero = (divisor == '0);
    // Zero divisor takes precedence: it reports div_zero only, never overflow.
    ovf      = ~div_zero & (|quo[DW-1:N-1]);
    mag      = (div_zero | ovf) ? MAG_MAX : quo[N-2:0];
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state      <= ST_IDLE;
      busy_o     <= 1'b0;
      ready_o    <= 1'b0;
      result_o   <= '0;
      div_zero_o <= 1'b0;
      overflow_o <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      divisor    <= '0;
      sign       <= 1'b0;
      cnt        <= '0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            sign    <= opA_i[SIGN_BIT] ^ opB_i[SIGN_BIT];
            quo     <= {opA_i[N-2:0], {Q{1'b0}}};
            divisor <= opB_i[N-2:0];
            rem     <= '0;
            cnt     <= '0;
            busy_o  <= 1'b1;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_o   <= {sign, mag};
          div_zero_o <= div_zero;
          overflow_o <= ovf;
          ready_o    <= 1'b1;
          busy_o     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_div.sv
// Self-checking bench for fixed_div (Q=16, N=32) with a plain-arithmetic
// reference model of sign-magnitude division.
module tb_fixed_div;
  localparam int Q = 16;
  localparam int N = 32;
  localparam int LAT = N + Q;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        busy, ready, dz, ov;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fixed_div #(.Q(Q), .N(N)) dut (
    .clk_i(clk), .nrst_i(nrst), .valid_i(valid), .opA_i(opa), .opB_i(opb),
    .busy_o(busy), .ready_o(ready), .result_o(result),
    .div_zero_o(dz), .overflow_o(ov)
  );

  // Reference: exact integer division of magnitudes, saturate, XOR signs.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic mdz, output logic mov);
    logic [63:0] num, den, q;
    logic [30:0] mag;
    num = 64'(a[30:0]) << Q;
    den = 64'(b[30:0]);
    mdz = 1'b0;
    mov = 1'b0;
    if (den == 0) begin
      mag = '1;
      mdz = 1'b1;
    end else begin
      q = num / den;
      if (q > 64'h7FFF_FFFF) begin
        mag = '1;
        mov = 1'b1;
      end else begin
        mag = q[30:0];
      end
    end
    r = {a[31] ^ b[31], mag};
  endfunction

  // Present operands now, let the next edge accept them, then scramble inputs.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    opa = a;
    opb = b;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    opa = $urandom;
    opb = $urandom;
  endtask

  task automatic wait_ready(output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ready_timeout: ready_o not seen after %0d cycles, required within 200", lat);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic rdz, output logic rov, output int lat);
    start_op(a, b);
    wait_ready(lat);
    r = result;
    rdz = dz;
    rov = ov;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", dz); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", ov); end
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] ta[3] = '{32'h0006_0000, 32'h8001_8000, 32'h0001_0000};
    logic [31:0] tb[3] = '{32'h0002_0000, 32'h0000_8000, 32'h0003_0000};
    logic [31:0] te[3] = '{32'h0003_0000, 32'h8003_0000, 32'h0000_5555};
    logic [31:0] r;
    logic rdz, rov;
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      do_op(ta[i], tb[i], r, rdz, rov, lat);
      checks++; if (r !== te[i]) begin errors++; $display("FAIL basic_result[%0d]: got %h want %h", i, r, te[i]); end
      checks++; if ({rdz, rov} !== 2'b00) begin errors++; $display("FAIL basic_flags[%0d]: got %b want 00", i, {rdz, rov}); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  // Zero divisors, saturation, exact-max boundary and negative-zero output.
  task automatic test_edges();
    logic [31:0] ta[6] = '{32'h0001_0000, 32'h8001_0000, 32'h0000_0000,
                           32'h4000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] tb[6] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
                           32'h0000_0100, 32'h0001_0000, 32'h0000_FFFF};
    logic [31:0] te[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                           32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [1:0]  tf[6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b01};
    logic [31:0] r;
    logic rdz, rov;
    int lat;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      do_op(ta[i], tb[i], r, rdz, rov, lat);
      checks++; if (r !== te[i]) begin errors++; $display("FAIL edge_result[%0d]: got %h want %h", i, r, te[i]); end
      checks++; if ({rdz, rov} !== tf[i]) begin errors++; $display("FAIL edge_flags[%0d] dz,ov: got %b want %b", i, {rdz, rov}, tf[i]); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL edge_latency[%0d]: got %0d want %0d", i, lat, LAT); end
    end
    // Negative zero quotient keeps its sign
    @(posedge clk);
    #1;
    do_op(32'h8000_0000, 32'h0001_0000, r, rdz, rov, lat);
    checks++; if ({r, rdz, rov} !== {32'h8000_0000, 2'b00}) begin
      errors++; $display("FAIL neg_zero: got %h/%b%b want 80000000/00", r, rdz, rov);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic rdz, rov, edz, eov;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = {1'($urandom), 31'($urandom_range(0, 1023))};
        2: begin a = {1'($urandom), 31'($urandom_range(0, 32'h000F_FFFF))}; b = {1'($urandom), 31'($urandom_range(32'h0001_0000, 32'h00FF_FFFF))}; end
        default: b = {1'($urandom), 31'($urandom_range(0, 3))};
      endcase
      model(a, b, er, edz, eov);
      @(posedge clk);
      #1;
      do_op(a, b, r, rdz, rov, lat);
      checks++; if (r !== er) begin errors++; $display("FAIL rand_result[%0d] %h/%h: got %h want %h", i, a, b, r, er); end
      checks++; if ({rdz, rov} !== {edz, eov}) begin errors++; $display("FAIL rand_flags[%0d] %h/%h: got %b want %b", i, a, b, {rdz, rov}, {edz, eov}); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  // valid_i stays high with changing operands; only the first op counts.
  task automatic test_hold_valid();
    int lat;
    bit seen;
    @(posedge clk);
    #1;
    opa = 32'h0006_0000;
    opb = 32'h0002_0000;
    valid = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      opa = $urandom;
      opb = $urandom;
      @(posedge clk);
      #1;
      lat++;
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL hold_timeout: ready_o not seen after %0d cycles", lat); end
    checks++; if (result !== 32'h0003_0000) begin errors++; $display("FAIL hold_result: got %h want 00030000", result); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL hold_latency: got %0d want %0d", lat, LAT); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_extra_op: busy got %b want 0", busy); end
  endtask

  // Second op offered in the ready_o cycle is accepted on the following edge.
  task automatic test_back_to_back();
    int lat;
    @(posedge clk);
    #1;
    start_op(32'h0001_0000, 32'h0003_0000);
    wait_ready(lat);
    checks++; if (result !== 32'h0000_5555) begin errors++; $display("FAIL b2b_first: got %h want 00005555", result); end
    start_op(32'h8006_0000, 32'h0002_0000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
    wait_ready(lat);
    checks++; if (result !== 32'h8003_0000) begin errors++; $display("FAIL b2b_second: got %h want 80030000", result); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic rdz, rov;
    int lat;
    @(posedge clk);
    #1;
    start_op(32'h7FFF_0000, 32'h0003_0000);
    repeat (19) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 00000000", result); end
    checks++; if ({dz, ov} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b want 00", {dz, ov}); end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    do_op(32'h0006_0000, 32'h0002_0000, r, rdz, rov, lat);
    checks++; if (r !== 32'h0003_0000) begin errors++; $display("FAIL midrst_next: got %h want 00030000", r); end
    checks++; if ({rdz, rov} !== 2'b00) begin errors++; $display("FAIL midrst_next_flags: got %b want 00", {rdz, rov}); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_random();
    test_hold_valid();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
